// File: rtl/dm_pkg.sv
// Shared types and width helpers for the dot-matrix cursor controller.
// Key vectors are packed {up, right, down, left}.
package dm_pkg;

    typedef enum logic {
        DM_OFF = 1'b0,
        DM_RUN = 1'b1
    } dm_state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dm_dir_t;

    localparam logic [3:0] KEY_UP    = 4'b1000;
    localparam logic [3:0] KEY_RIGHT = 4'b0100;
    localparam logic [3:0] KEY_DOWN  = 4'b0010;
    localparam logic [3:0] KEY_LEFT  = 4'b0001;

    // Width of a counter or index spanning n values, never narrower than one bit.
    function automatic int dm_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_key_repeat.sv
// Key history, single-key press detection and held-key auto-repeat.
// o_move is a one-cycle strobe; o_dir names the key that caused it.
module dm_key_repeat
    import dm_pkg::*;
#(
    parameter int REPEAT_CYCLES = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_en,
    input  logic [3:0] i_keys,
    output logic      o_move,
    output dm_dir_t   o_dir
);

    localparam int CNTW = dm_width(REPEAT_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST =
        (REPEAT_CYCLES > 0) ? CNTW'(REPEAT_CYCLES - 1) : '0;

    logic [3:0]      r_keys_prev;
    logic [3:0]      r_held;
    logic            r_armed;
    logic [CNTW-1:0] r_cnt;

    logic    w_single;
    logic    w_press;
    logic    w_hold;
    logic    w_tick;
    dm_dir_t w_dir;

    assign w_single = (i_keys != 4'd0) && ((i_keys & (i_keys - 4'd1)) == 4'd0);
    assign w_press  = w_single && ((i_keys & ~r_keys_prev) != 4'd0);
    // Repeat only continues a hold that began with a real press while enabled.
    assign w_hold   = w_single && r_armed && (i_keys == r_held);
    assign w_tick   = (REPEAT_CYCLES > 0) && w_hold && (r_cnt == CNT_LAST);

    always_comb begin
        w_dir = DIR_NONE;
        case (i_keys)
            KEY_UP:    w_dir = DIR_UP;
            KEY_RIGHT: w_dir = DIR_RIGHT;
            KEY_DOWN:  w_dir = DIR_DOWN;
            KEY_LEFT:  w_dir = DIR_LEFT;
            default:   w_dir = DIR_NONE;
        endcase
    end

    assign o_move = i_en && (w_press || w_tick);
    assign o_dir  = o_move ? w_dir : DIR_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys_prev <= 4'd0;
            r_held      <= 4'd0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_keys_prev <= i_keys;
            if (!i_en) begin
                r_armed <= 1'b0;
                r_cnt   <= '0;
            end else if (w_press) begin
                r_armed <= 1'b1;
                r_held  <= i_keys;
                r_cnt   <= '0;
            end else if (w_hold) begin
                r_cnt <= w_tick ? '0 : r_cnt + CNTW'(1);
            end else begin
                r_armed <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/dot_matrix_cursor.sv
// Cursor controller for a ROWS x COLS dot matrix: power FSM, wrapping cursor,
// trail memory and registered mat encoder. mat bit r*COLS+c is row r, column c.
module dot_matrix_cursor
    import dm_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int REPEAT_CYCLES = 0,
    localparam int RW           = dm_width(ROWS),
    localparam int CLW          = dm_width(COLS),
    localparam int NCELL        = ROWS * COLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power,
    input  logic             up,
    input  logic             right,
    input  logic             down,
    input  logic             left,
    input  logic             trail,
    input  logic             clear,
    output logic [NCELL-1:0] mat,
    output logic [RW-1:0]    row,
    output logic [CLW-1:0]   col,
    output dm_state_t        o_dbg_state
);

    localparam logic [NCELL-1:0] CELL0 = NCELL'(1);

    dm_state_t        r_state;
    logic [RW-1:0]    r_row;
    logic [CLW-1:0]   r_col;
    logic [NCELL-1:0] r_mem;
    logic             r_started;
    logic [NCELL-1:0] r_mat;

    dm_state_t        w_state_next;
    logic [RW-1:0]    w_row_next;
    logic [CLW-1:0]   w_col_next;
    logic [NCELL-1:0] w_mem_next;
    logic             w_started_next;
    logic [NCELL-1:0] w_mat_next;
    logic [NCELL-1:0] w_cell;
    logic             w_step;
    logic             w_en;
    logic             w_move;
    dm_dir_t          w_dir;

    assign w_en = (r_state == DM_RUN) && power;

    dm_key_repeat #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_keys (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_keys ({up, right, down, left}),
        .o_move (w_move),
        .o_dir  (w_dir)
    );

    // A clear on the same edge as a move wins and the move is dropped.
    assign w_step = w_move && !clear;

    always_comb begin
        w_state_next   = r_state;
        w_row_next     = r_row;
        w_col_next     = r_col;
        w_mem_next     = r_mem;
        w_started_next = r_started;
        w_cell         = '0;
        w_mat_next     = '0;

        case (r_state)
            DM_OFF:  if (power) w_state_next = DM_RUN;
            DM_RUN:  if (!power) w_state_next = DM_OFF;
            default: w_state_next = DM_OFF;
        endcase

        if (!power) begin
            w_row_next     = '0;
            w_col_next     = '0;
            w_mem_next     = '0;
            w_started_next = 1'b0;
        end else begin
            if (w_step) begin
                case (w_dir)
                    DIR_UP:    w_row_next = (r_row == '0) ? RW'(ROWS - 1) : r_row - RW'(1);
                    DIR_DOWN:  w_row_next = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
                    DIR_LEFT:  w_col_next = (r_col == '0) ? CLW'(COLS - 1) : r_col - CLW'(1);
                    DIR_RIGHT: w_col_next = (r_col == CLW'(COLS - 1)) ? '0 : r_col + CLW'(1);
                    default:   ;
                endcase
            end
            w_cell = CELL0 << (int'(w_row_next) * COLS + int'(w_col_next));
            // The first trail-enabled cycle marks the cell the cursor is sitting on.
            if (clear)
                w_mem_next = '0;
            else if (trail && (w_step || !r_started))
                w_mem_next = r_mem | w_cell;
            w_started_next = r_started | trail;
            w_mat_next     = w_cell | (trail ? w_mem_next : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DM_OFF;
            r_row     <= '0;
            r_col     <= '0;
            r_mem     <= '0;
            r_started <= 1'b0;
            r_mat     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_mem     <= w_mem_next;
            r_started <= w_started_next;
            r_mat     <= w_mat_next;
        end
    end

    assign mat         = r_mat;
    assign row         = r_row;
    assign col         = r_col;
    assign o_dbg_state = r_state;

endmodule

// File: doc/dot_matrix_cursor.md
# dot_matrix_cursor

Parametrised cursor controller for a ROWS x COLS LED dot matrix, successor to the fixed 4x4 cursor block. Four direction keys move a single lit cursor with wrap-around, and each key auto-repeats while held. A trail mode keeps every visited dot lit until cleared. The block sits between the key front-end (synchronised, debounced levels) and the matrix row/column driver.

## Interface
- ROWS, 4, matrix rows (2..64)
- COLS, 4, matrix columns (2..64)
- REPEAT_CYCLES, 0, held-key auto-repeat period in clk cycles; 0 disables repeat
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- power  input  1  0 forces OFF state; 1 enables operation
- up, right, down, left  input  1 each  direction key levels, already synchronous to clk
- trail  input  1  0 = cursor mode, 1 = trail mode
- clear  input  1  erase trail memory
- mat  output  ROWS*COLS  lit dots; bit r*COLS+c is row r, column c; registered
- row  output  $clog2(ROWS)  cursor row; registered
- col  output  $clog2(COLS)  cursor column; registered

## Operation
- Reset: state OFF, row=0, col=0, trail memory 0, mat=0, key history 0, repeat counter 0.
- FSM states:
  - OFF: mat=0; row/col held at 0; trail memory 0; keys ignored. OFF -> RUN when power=1.
  - RUN: cursor is active. RUN -> OFF when power=0. On entry to OFF, cursor and trail are reset to 0.
- Move event: exactly one key has a rising edge (sampled 1 now, 0 on the previous edge) while the other three are sampled 0, or a repeat tick.
  - Two or more keys high in the same cycle: no move, and the repeat counter is reset.
- Moves with wrap-around:
  - up: row-1, 0 -> ROWS-1
  - down: row+1, ROWS-1 -> 0
  - left: col-1, 0 -> COLS-1
  - right: col+1, COLS-1 -> 0
- Auto-repeat (REPEAT_CYCLES>0):
  - While the same single key stays high, the counter increments every cycle.
  - When the counter reaches REPEAT_CYCLES-1, a repeat tick fires and the counter reloads to 0. Steps occur every REPEAT_CYCLES cycles after the initial press step.
  - Key release or a change of key resets the counter.
- Trail memory (ROWS*COLS bits):
  - When trail=1 and a move occurs, the bit at the new position is set.
  - The starting cell is set on the first RUN cycle with trail=1.
- clear=1 zeroes the trail memory. If clear and a move coincide, clear has priority and the move is dropped.
- mat = one-hot(cursor) | (trail ? trail_mem : 0).
  - Changing trail from 1 to 0 hides the trail without erasing it. Changing back to 1 shows it again.

## Timing
- Move latency: row, col and mat update on the same rising edge at which the key is first sampled high. Outputs are valid one edge after the key input rises.
- OFF -> RUN: mat shows bit 0 set on the first edge with power=1 (rst=0).
- rst has priority over power, keys and clear. Reset asserted mid-hold discards the key history, so a key still held after reset is not a new press.
- power=0 mid-hold: next edge gives mat=0, row=0, col=0. A key still held when power returns does not move the cursor until it is released and pressed again.
- Repeat with REPEAT_CYCLES=N: the press step happens at edge k, then further steps at k+N, k+2N, … while the key is held.
- Widths: row/col arithmetic is performed at $clog2 width with explicit wrap compare. No reliance on natural overflow; ROWS and COLS need not be powers of two.

## Structure
- Package dm_pkg:
  - state enum {DM_OFF, DM_RUN}
  - direction enum {DIR_NONE, DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT}
  - localparam helpers for row/col widths
- Sub-module dm_key_repeat:
  - Contains the 4-key history register, the single-key/edge detect and the repeat counter.
  - Outputs a one-cycle move strobe plus its direction.
- The top level holds the FSM, the cursor registers, the trail memory and the mat encoder.

## Test plan
- Reset then power=1, ROWS=4, COLS=5: mat=bit 0, row=0, col=0. One pulse each of up and left: row=3, col=4, mat bit 19 only.
- Four right pulses on COLS=4 with trail=1: col sequence 1,2,3,0. mat bits 0..3 set. Drop trail to 0: only bit 0 set. Raise trail to 1: bits 0..3 set again.
- REPEAT_CYCLES=3, hold down for 10 cycles from edge k: row steps at k, k+3, k+6, k+9 (ROWS=4 gives 1,2,3,0). Release: no further steps.
- up and right rise on the same edge: row and col unchanged. A later single right pulse moves col by 1.
- clear asserted on the same edge as a right press with trail=1: trail memory becomes 0, col unchanged, mat shows cursor only.
- power dropped while holding left, then restored with left still high: mat=0 while OFF. After restore, cursor at (0,0) and no move until left is re-pressed.
